mcb_cmd_arbiter: RTL

Shares the single 32-bit MCB user command port of the DDR3 test design between one write client and one read client. Grants one request at a time in round-robin order and holds a write until the MCB write FIFO contains the full burst. Issues exactly one MCB command per grant and returns a one-cycle done pulse to the owner. Sits between the user write/read generators and the MCB command port, and owns all command-port signals.

---
 rtl/mcb_arb_pkg.sv | 26 ++
 rtl/mcb_cmd_arbiter_if.sv | 46 ++++
 rtl/mcb_wait_timer.sv | 25 ++
 rtl/mcb_cmd_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mcb_arb_pkg.sv
// Shared encodings for the MCB command-port arbiter: FSM states, MCB
// instruction codes, burst limit and the owner tag.
package mcb_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  localparam int MAX_BL = 64;

  typedef enum logic {
    OWNER_WR = 1'b0,
    OWNER_RD = 1'b1
  } owner_e;

  // Round-robin pick: on a tie the client that did not own the port last wins.
  function automatic owner_e pick_owner(logic wr_req, logic rd_req, owner_e last_owner);
    if (wr_req && rd_req) return (last_owner == OWNER_WR) ? OWNER_RD : OWNER_WR;
    return wr_req ? OWNER_WR : OWNER_RD;
  endfunction

endpackage

// File: rtl/mcb_cmd_arbiter_if.sv
// Client request/grant signals, MCB command-port signals and status for the
// arbiter; master is the arbiter side, slave is the surrounding design.
interface mcb_cmd_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int LEN_W  = 7
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_gnt;
    logic              wr_done;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_gnt;
    logic              rd_done;

    logic [6:0]        mcb_wr_count;
    logic              mcb_cmd_full;
    logic              mcb_cmd_en;
    logic [2:0]        mcb_cmd_instr;
    logic [ADDR_W-1:0] mcb_cmd_addr;
    logic [5:0]        mcb_cmd_bl;

    logic              timeout_err;
    logic              len_err;
    logic [15:0]       wr_cmds;
    logic [15:0]       rd_cmds;

    modport master (
        input  wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len,
        input  mcb_wr_count, mcb_cmd_full,
        output wr_gnt, wr_done, rd_gnt, rd_done,
        output mcb_cmd_en, mcb_cmd_instr, mcb_cmd_addr, mcb_cmd_bl,
        output timeout_err, len_err, wr_cmds, rd_cmds
    );

    modport slave (
        output wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len,
        output mcb_wr_count, mcb_cmd_full,
        input  wr_gnt, wr_done, rd_gnt, rd_done,
        input  mcb_cmd_en, mcb_cmd_instr, mcb_cmd_addr, mcb_cmd_bl,
        input  timeout_err, len_err, wr_cmds, rd_cmds
    );
endinterface

// File: rtl/mcb_wait_timer.sv
// GRANT wait counter: counts enabled cycles from zero and flags expire once
// TIMEOUT is reached; holds there until cleared.
module mcb_wait_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (en && !expire)
            count <= count + W'(1);
    end

    assign expire = (count == LIMIT);
endmodule

// File: rtl/mcb_cmd_arbiter.sv
// Round-robin arbiter sharing the MCB user command port between one write and
// one read client; one command per grant, done pulse back to the owner.
module mcb_cmd_arbiter
    import mcb_arb_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int LEN_W   = 7,
    parameter int TIMEOUT = 1023
) (
    input logic              clk,
    input logic              rst_n,
    mcb_cmd_arbiter_if.master bus
);
    logic [1:0]        state;
    owner_e            owner;
    owner_e            last_owner;
    owner_e            sel_owner;
    logic [ADDR_W-3:0] lat_addr_hi;
    logic [LEN_W-1:0]  lat_len;

    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [5:0]        cmd_bl;
    logic              timeout_err;
    logic              len_err;
    logic [15:0]       wr_cmds;
    logic [15:0]       rd_cmds;

    logic              len_bad;
    logic              ready;
    logic              expire;

    assign sel_owner = pick_owner(bus.wr_req, bus.rd_req, last_owner);
    assign len_bad   = (lat_len == '0) || (32'(lat_len) > MAX_BL);
    // Reads never wait; a write waits until its whole burst sits in the write FIFO.
    assign ready     = (owner == OWNER_RD) || (32'(bus.mcb_wr_count) >= 32'(lat_len));

    mcb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_DONE),
        .en     (state == ST_GRANT),
        .expire (expire)
    );

    // NOTE: non-blocking (<=) for every register so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= OWNER_WR;
            last_owner  <= OWNER_RD;
            lat_addr_hi <= '0;
            lat_len     <= '0;
            cmd_en      <= 1'b0;
            cmd_instr   <= '0;
            cmd_addr    <= '0;
            cmd_bl      <= '0;
            timeout_err <= 1'b0;
            len_err     <= 1'b0;
            wr_cmds     <= '0;
            rd_cmds     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.wr_req || bus.rd_req) begin
                        owner       <= sel_owner;
                        last_owner  <= sel_owner;
                        lat_addr_hi <= (sel_owner == OWNER_WR) ? bus.wr_addr[ADDR_W-1:2]
                                                               : bus.rd_addr[ADDR_W-1:2];
                        lat_len     <= (sel_owner == OWNER_WR) ? bus.wr_len : bus.rd_len;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (len_bad) begin
                        len_err <= 1'b1;
                        state   <= ST_DONE;
                    end else if (ready && !bus.mcb_cmd_full) begin
                        cmd_en    <= 1'b1;
                        cmd_instr <= (owner == OWNER_WR) ? INSTR_WR : INSTR_RD;
                        cmd_addr  <= {lat_addr_hi, 2'b00};
                        cmd_bl    <= 6'(lat_len - LEN_W'(1));
                        state     <= ST_ISSUE;
                    end else if (expire) begin
                        timeout_err <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    cmd_en <= 1'b0;
                    if (owner == OWNER_WR) wr_cmds <= wr_cmds + 16'd1;
                    else                   rd_cmds <= rd_cmds + 16'd1;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_gnt        = (state != ST_IDLE) && (owner == OWNER_WR);
    assign bus.rd_gnt        = (state != ST_IDLE) && (owner == OWNER_RD);
    assign bus.wr_done       = (state == ST_DONE) && (owner == OWNER_WR);
    assign bus.rd_done       = (state == ST_DONE) && (owner == OWNER_RD);
    assign bus.mcb_cmd_en    = cmd_en;
    assign bus.mcb_cmd_instr = cmd_instr;
    assign bus.mcb_cmd_addr  = cmd_addr;
    assign bus.mcb_cmd_bl    = cmd_bl;
    assign bus.timeout_err   = timeout_err;
    assign bus.len_err       = len_err;
    assign bus.wr_cmds       = wr_cmds;
    assign bus.rd_cmds       = rd_cmds;
endmodule
